// File: rtl/apb_slave_regfile.sv
// APB completer register file: read-only ID at address 0, RW storage above it,
// programmable wait states, error response for unmapped or ID writes.
module apb_slave_regfile #(
    parameter int                    ADDR_WIDTH  = 7,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    DEPTH       = 64,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 8'hA5
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic                   in_range;
    logic                   is_id;
    logic                   err;
    logic                   wr_en;
    logic [IDX_W-1:0]       idx;
    logic [DATA_WIDTH-1:0]  rd_val;

    assign in_range = 32'(PADDR) < 32'(DEPTH);
    assign is_id    = (PADDR == '0);
    assign err      = !in_range || (PWRITE && is_id);
    assign idx      = PADDR[IDX_W-1:0];
    assign rd_val   = is_id ? ID_VALUE : mem_q[idx];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) state_d = SETUP;
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (!PSEL || !PENABLE) begin
                    state_d = IDLE;
                end else if (cnt_q == WAIT_C) begin
                    PREADY  = 1'b1;
                    PSLVERR = err;
                    wr_en   = PWRITE && !err;
                    if (!PWRITE && !err) PRDATA = rd_val;
                    // PENABLE is high here, so the next setup phase is
                    // picked up from IDLE on the following edge.
                    state_d = (PSEL && !PENABLE) ? SETUP : IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[idx] <= PWDATA;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: three builds (WAIT 1, 0, 3) driven
// by directed APB transfers; a negedge monitor checks every completion.
module tb_apb_slave_regfile;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       psel    [N];
    logic       penable [N];
    logic       pwrite  [N];
    logic [6:0] paddr   [N];
    logic [7:0] pwdata  [N];
    logic [7:0] prdata  [N];
    logic       pready  [N];
    logic       pslverr [N];

    typedef struct {
        int       d;
        logic [7:0] data;
        bit       err;
        int       lat;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   acc [N];

    always #5 clk = ~clk;

    function automatic int wv(int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        apb_slave_regfile #(
            .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .PCLK   (clk),
            .PRESET (rst_n),
            .PSEL   (psel[g]),
            .PENABLE(penable[g]),
            .PWRITE (pwrite[g]),
            .PADDR  (paddr[g]),
            .PWDATA (pwdata[g]),
            .PRDATA (prdata[g]),
            .PREADY (pready[g]),
            .PSLVERR(pslverr[g])
        );
    end

    // Monitor: count PENABLE cycles, pop and compare on every PREADY.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < N; d++) begin
            if (rst_n && psel[d] && penable[d]) acc[d]++;
            else acc[d] = 0;
            if (pready[d] === 1'b1) begin
                vectors++;
                if (sb.size() == 0 || sb[0].d != d) begin
                    $display("FAIL unexpected_ready dut%0d addr=%0d: PREADY=1, no transfer pending",
                             d, paddr[d]);
                    miscompares++;
                end else begin
                    e = sb.pop_front();
                    if (pslverr[d] !== e.err || prdata[d] !== e.data || acc[d] != e.lat) begin
                        $display("FAIL xfer dut%0d addr=%0d: got err=%b data=%h lat=%0d, want err=%b data=%h lat=%0d",
                                 d, paddr[d], pslverr[d], prdata[d], acc[d], e.err, e.data, e.lat);
                        miscompares++;
                    end
                end
                acc[d] = 0;
            end else if (pslverr[d] !== 1'b0 || prdata[d] !== 8'h00) begin
                $display("FAIL idle_outputs dut%0d: got err=%b data=%h, want 0/00",
                         d, pslverr[d], prdata[d]);
                miscompares++;
            end
        end
    end

    task automatic check(string nm, logic [9:0] act, logic [9:0] exp);
        vectors++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, want %h", nm, act, exp);
            miscompares++;
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(int d, bit wr, logic [7:0] exp_d, bit exp_err);
        exp_t e;
        e.d    = d;
        e.data = wr ? 8'h00 : exp_d;
        e.err  = exp_err;
        // One PENABLE cycle is spent in SETUP before the wait states count.
        e.lat  = wv(d) + 2;
        sb.push_back(e);
    endtask

    task automatic setup(int d, bit wr, logic [6:0] a, logic [7:0] wd);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = a;
        pwdata[d]  = wd;
        @(posedge clk);
        #1 penable[d] = 1'b1;
    endtask

    task automatic wait_ready(int d, output bit done);
        done = 1'b0;
        for (int k = 0; k < 32 && !done; k++) begin
            @(negedge clk);
            done = pready[d];
        end
        if (!done) begin
            $display("FAIL timeout dut%0d addr=%0d: PREADY=0 after 32 cycles, want 1",
                     d, paddr[d]);
            vectors++;
            miscompares++;
            void'(sb.pop_back());
        end
    endtask

    task automatic xfer(int d, bit wr, logic [6:0] a, logic [7:0] wd,
                        logic [7:0] exp_d, bit exp_err);
        bit done;
        push(d, wr, exp_d, exp_err);
        setup(d, wr, a, wd);
        wait_ready(d, done);
        @(posedge clk);
        #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    task automatic abort_xfer(int d, logic [6:0] a, logic [7:0] wd, int n);
        setup(d, 1'b1, a, wd);
        idle(n);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        idle(2);
    endtask

    task automatic reset_at_ready(int d, bit wr, logic [6:0] a, logic [7:0] wd,
                                  logic [7:0] exp_d);
        bit done;
        push(d, wr, exp_d, 1'b0);
        setup(d, wr, a, wd);
        wait_ready(d, done);
        #1 rst_n = 1'b0;
        #1 check("reset_at_ready", {pready[d], pslverr[d], prdata[d]}, 10'h000);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < N; d++) begin
            psel[d]    = 1'b0;
            penable[d] = 1'b0;
            pwrite[d]  = 1'b0;
            paddr[d]   = '0;
            pwdata[d]  = '0;
            acc[d]     = 0;
        end
        idle(2);
        for (int d = 0; d < N; d++)
            check($sformatf("reset_out_dut%0d", d),
                  {pready[d], pslverr[d], prdata[d]}, 10'h000);
        rst_n = 1'b1;
        idle(1);

        xfer(0, 1'b1, 7'd5, 8'h3C, 8'h00, 1'b0);
        idle(1);
        xfer(0, 1'b0, 7'd5, 8'h00, 8'h3C, 1'b0);

        xfer(0, 1'b0, 7'd0, 8'h00, 8'hA5, 1'b0);
        xfer(0, 1'b1, 7'd0, 8'h11, 8'h00, 1'b1);
        xfer(0, 1'b0, 7'd0, 8'h00, 8'hA5, 1'b0);

        xfer(0, 1'b1, 7'd70, 8'hFF, 8'h00, 1'b1);
        xfer(0, 1'b0, 7'd70, 8'h00, 8'h00, 1'b1);
        xfer(0, 1'b1, 7'd63, 8'h5A, 8'h00, 1'b0);
        xfer(0, 1'b0, 7'd63, 8'h00, 8'h5A, 1'b0);
        xfer(0, 1'b0, 7'd64, 8'h00, 8'h00, 1'b1);
        xfer(0, 1'b1, 7'd127, 8'hEE, 8'h00, 1'b1);

        xfer(0, 1'b1, 7'd1, 8'h01, 8'h00, 1'b0);
        xfer(0, 1'b1, 7'd2, 8'h02, 8'h00, 1'b0);
        xfer(0, 1'b0, 7'd1, 8'h00, 8'h01, 1'b0);
        xfer(0, 1'b0, 7'd2, 8'h00, 8'h02, 1'b0);
        idle(1);

        xfer(1, 1'b1, 7'd7, 8'hC3, 8'h00, 1'b0);
        xfer(1, 1'b0, 7'd7, 8'h00, 8'hC3, 1'b0);
        xfer(2, 1'b1, 7'd7, 8'h96, 8'h00, 1'b0);
        xfer(2, 1'b0, 7'd7, 8'h00, 8'h96, 1'b0);
        xfer(2, 1'b0, 7'd0, 8'h00, 8'hA5, 1'b0);
        idle(1);

        xfer(1, 1'b1, 7'd12, 8'h24, 8'h00, 1'b0);
        idle(1);
        abort_xfer(1, 7'd12, 8'h99, 1);
        xfer(1, 1'b0, 7'd12, 8'h00, 8'h24, 1'b0);
        xfer(2, 1'b1, 7'd12, 8'h42, 8'h00, 1'b0);
        idle(1);
        abort_xfer(2, 7'd12, 8'h99, 3);
        xfer(2, 1'b0, 7'd12, 8'h00, 8'h42, 1'b0);
        idle(1);

        setup(0, 1'b1, 7'd9, 8'h77);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_in_wait", {pready[0], pslverr[0], prdata[0]}, 10'h000);
        psel[0]    = 1'b0;
        penable[0] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        xfer(0, 1'b0, 7'd9, 8'h00, 8'h00, 1'b0);
        xfer(0, 1'b0, 7'd5, 8'h00, 8'h00, 1'b0);
        xfer(0, 1'b0, 7'd1, 8'h00, 8'h00, 1'b0);
        xfer(1, 1'b0, 7'd12, 8'h00, 8'h00, 1'b0);
        idle(1);

        reset_at_ready(2, 1'b0, 7'd0, 8'h00, 8'hA5);
        reset_at_ready(2, 1'b1, 7'd10, 8'h55, 8'h00);
        xfer(2, 1'b0, 7'd10, 8'h00, 8'h00, 1'b0);

        idle(3);
        check("scoreboard_empty", 10'(sb.size()), 10'h000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
